// File: rtl/toy_fetch_req_initiator.sv
// rtl/toy_fetch_req_initiator.sv - fetch-memory requester: in-order issue, out-of-order ack, registered refill
module toy_fetch_req_initiator #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 256,
  parameter int OPCODE_WIDTH = 2,
  parameter int ENTRY_NUM    = 4,
  parameter int IDX_WIDTH    = $clog2(ENTRY_NUM),
  parameter int ROB_ID_WIDTH = 4,
  parameter int ID_WIDTH     = OPCODE_WIDTH + IDX_WIDTH + ROB_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req_vld,
  output logic                    miss_req_rdy,
  input  logic [ADDR_WIDTH-1:0]   miss_req_addr,
  input  logic [OPCODE_WIDTH-1:0] miss_req_opcode,
  input  logic [ROB_ID_WIDTH-1:0] miss_req_rob_id,
  output logic                    fetch_mem_req_vld,
  input  logic                    fetch_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]   fetch_mem_req_addr,
  output logic [ID_WIDTH-1:0]     fetch_mem_req_entry_id,
  input  logic                    fetch_mem_ack_vld,
  output logic                    fetch_mem_ack_rdy,
  input  logic [DATA_WIDTH-1:0]   fetch_mem_ack_data,
  input  logic [ID_WIDTH-1:0]     fetch_mem_ack_entry_id,
  output logic                    refill_vld,
  input  logic                    refill_rdy,
  output logic [ADDR_WIDTH-1:0]   refill_addr,
  output logic [DATA_WIDTH-1:0]   refill_data,
  output logic [OPCODE_WIDTH-1:0] refill_opcode,
  output logic [ROB_ID_WIDTH-1:0] refill_rob_id,
  output logic [IDX_WIDTH:0]      outstanding_cnt,
  output logic                    err_unexp_ack
);

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_ISSUED, ST_DONE} ent_state_e;

  localparam logic [IDX_WIDTH:0] ONE = (IDX_WIDTH+1)'(1);

  ent_state_e              state_q  [ENTRY_NUM];
  ent_state_e              state_d  [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0]   addr_q   [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0]   addr_d   [ENTRY_NUM];
  logic [OPCODE_WIDTH-1:0] opcode_q [ENTRY_NUM];
  logic [OPCODE_WIDTH-1:0] opcode_d [ENTRY_NUM];
  logic [ROB_ID_WIDTH-1:0] rob_q    [ENTRY_NUM];
  logic [ROB_ID_WIDTH-1:0] rob_d    [ENTRY_NUM];
  logic [DATA_WIDTH-1:0]   data_q   [ENTRY_NUM];
  logic [DATA_WIDTH-1:0]   data_d   [ENTRY_NUM];
  logic [IDX_WIDTH-1:0]    fifo_q   [ENTRY_NUM];
  logic [IDX_WIDTH-1:0]    fifo_d   [ENTRY_NUM];
  logic [IDX_WIDTH:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic                    refill_vld_q, refill_vld_d;
  logic [ADDR_WIDTH-1:0]   refill_addr_q, refill_addr_d;
  logic [DATA_WIDTH-1:0]   refill_data_q, refill_data_d;
  logic [OPCODE_WIDTH-1:0] refill_opcode_q, refill_opcode_d;
  logic [ROB_ID_WIDTH-1:0] refill_rob_q, refill_rob_d;
  logic [IDX_WIDTH:0]      cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    free_found, done_found;
  logic [IDX_WIDTH-1:0]    alloc_idx, done_idx, head_idx, ack_idx;
  logic                    alloc_fire, req_fire, ack_fire, ack_hit;
  logic                    unused_ack_fields;

  // Lowest-index FREE and DONE entries, scanned from the top so the lowest wins.
  always_comb begin
    free_found = 1'b0;
    done_found = 1'b0;
    alloc_idx  = '0;
    done_idx   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        alloc_idx  = IDX_WIDTH'(i);
      end
      if (state_q[i] == ST_DONE) begin
        done_found = 1'b1;
        done_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign head_idx          = fifo_q[rd_ptr_q[IDX_WIDTH-1:0]];
  assign ack_idx           = fetch_mem_ack_entry_id[ROB_ID_WIDTH+IDX_WIDTH-1:ROB_ID_WIDTH];
  assign unused_ack_fields = ^{fetch_mem_ack_entry_id[ID_WIDTH-1:ROB_ID_WIDTH+IDX_WIDTH],
                               fetch_mem_ack_entry_id[ROB_ID_WIDTH-1:0]};

  assign miss_req_rdy           = !rst && free_found;
  assign fetch_mem_req_vld      = !rst && (wr_ptr_q != rd_ptr_q);
  assign fetch_mem_req_addr     = addr_q[head_idx];
  assign fetch_mem_req_entry_id = {opcode_q[head_idx], head_idx, rob_q[head_idx]};
  assign fetch_mem_ack_rdy      = !rst;

  assign alloc_fire = miss_req_vld && miss_req_rdy;
  assign req_fire   = fetch_mem_req_vld && fetch_mem_req_rdy;
  assign ack_fire   = fetch_mem_ack_vld && fetch_mem_ack_rdy;
  assign ack_hit    = state_q[ack_idx] == ST_ISSUED;

  // Each event acts on an entry in a distinct state, so they never collide on one entry.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    opcode_d        = opcode_q;
    rob_d           = rob_q;
    data_d          = data_q;
    fifo_d          = fifo_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    refill_vld_d    = refill_vld_q;
    refill_addr_d   = refill_addr_q;
    refill_data_d   = refill_data_q;
    refill_opcode_d = refill_opcode_q;
    refill_rob_d    = refill_rob_q;
    err_d           = 1'b0;
    cnt_d           = '0;
    if (alloc_fire) begin
      state_d[alloc_idx]                 = ST_PEND;
      addr_d[alloc_idx]                  = miss_req_addr;
      opcode_d[alloc_idx]                = miss_req_opcode;
      rob_d[alloc_idx]                   = miss_req_rob_id;
      fifo_d[wr_ptr_q[IDX_WIDTH-1:0]]    = alloc_idx;
      wr_ptr_d                           = wr_ptr_q + ONE;
    end
    if (req_fire) begin
      state_d[head_idx] = ST_ISSUED;
      rd_ptr_d          = rd_ptr_q + ONE;
    end
    if (ack_fire) begin
      if (ack_hit) begin
        state_d[ack_idx] = ST_DONE;
        data_d[ack_idx]  = fetch_mem_ack_data;
      end else begin
        err_d = 1'b1;
      end
    end
    if (!refill_vld_q || refill_rdy) begin
      if (done_found) begin
        refill_vld_d      = 1'b1;
        refill_addr_d     = addr_q[done_idx];
        refill_data_d     = data_q[done_idx];
        refill_opcode_d   = opcode_q[done_idx];
        refill_rob_d      = rob_q[done_idx];
        state_d[done_idx] = ST_FREE;
      end else begin
        refill_vld_d = 1'b0;
      end
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (state_d[i] != ST_FREE) cnt_d = cnt_d + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        state_q[i]  <= ST_FREE;
        addr_q[i]   <= '0;
        opcode_q[i] <= '0;
        rob_q[i]    <= '0;
        data_q[i]   <= '0;
        fifo_q[i]   <= '0;
      end
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      refill_vld_q    <= 1'b0;
      refill_addr_q   <= '0;
      refill_data_q   <= '0;
      refill_opcode_q <= '0;
      refill_rob_q    <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      opcode_q        <= opcode_d;
      rob_q           <= rob_d;
      data_q          <= data_d;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      refill_vld_q    <= refill_vld_d;
      refill_addr_q   <= refill_addr_d;
      refill_data_q   <= refill_data_d;
      refill_opcode_q <= refill_opcode_d;
      refill_rob_q    <= refill_rob_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
    end
  end

  assign refill_vld      = refill_vld_q;
  assign refill_addr     = refill_addr_q;
  assign refill_data     = refill_data_q;
  assign refill_opcode   = refill_opcode_q;
  assign refill_rob_id   = refill_rob_q;
  assign outstanding_cnt = cnt_q;
  assign err_unexp_ack   = err_q;

endmodule

// File: tb/tb_toy_fetch_req_initiator.sv
// tb/tb_toy_fetch_req_initiator.sv - directed self-checking bench for toy_fetch_req_initiator
module tb_toy_fetch_req_initiator;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req_vld, miss_req_rdy;
  logic [31:0]  miss_req_addr;
  logic [1:0]   miss_req_opcode;
  logic [3:0]   miss_req_rob_id;
  logic         fetch_mem_req_vld, fetch_mem_req_rdy;
  logic [31:0]  fetch_mem_req_addr;
  logic [7:0]   fetch_mem_req_entry_id;
  logic         fetch_mem_ack_vld, fetch_mem_ack_rdy;
  logic [255:0] fetch_mem_ack_data;
  logic [7:0]   fetch_mem_ack_entry_id;
  logic         refill_vld, refill_rdy;
  logic [31:0]  refill_addr;
  logic [255:0] refill_data;
  logic [1:0]   refill_opcode;
  logic [3:0]   refill_rob_id;
  logic [2:0]   outstanding_cnt;
  logic         err_unexp_ack;

  int n_assert = 0;
  int n_fail   = 0;

  toy_fetch_req_initiator dut (
    .clk(clk), .rst(rst),
    .miss_req_vld(miss_req_vld), .miss_req_rdy(miss_req_rdy),
    .miss_req_addr(miss_req_addr), .miss_req_opcode(miss_req_opcode),
    .miss_req_rob_id(miss_req_rob_id),
    .fetch_mem_req_vld(fetch_mem_req_vld), .fetch_mem_req_rdy(fetch_mem_req_rdy),
    .fetch_mem_req_addr(fetch_mem_req_addr), .fetch_mem_req_entry_id(fetch_mem_req_entry_id),
    .fetch_mem_ack_vld(fetch_mem_ack_vld), .fetch_mem_ack_rdy(fetch_mem_ack_rdy),
    .fetch_mem_ack_data(fetch_mem_ack_data), .fetch_mem_ack_entry_id(fetch_mem_ack_entry_id),
    .refill_vld(refill_vld), .refill_rdy(refill_rdy),
    .refill_addr(refill_addr), .refill_data(refill_data),
    .refill_opcode(refill_opcode), .refill_rob_id(refill_rob_id),
    .outstanding_cnt(outstanding_cnt), .err_unexp_ack(err_unexp_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_data(input int k);
    return {8{32'hC0DE0000 + 32'(k)}};
  endfunction

  function automatic logic [7:0] eid(input int op, input int idx, input int rob);
    return {2'(op), 2'(idx), 4'(rob)};
  endfunction

  task automatic send_ack(input int op, input int idx, input int rob, input int k);
    fetch_mem_ack_vld      = 1'b1;
    fetch_mem_ack_entry_id = eid(op, idx, rob);
    fetch_mem_ack_data     = line_data(k);
  endtask

  int ack_order [4] = '{2, 0, 3, 1};

  initial begin
    rst = 1'b1;
    miss_req_vld = 1'b0; miss_req_addr = '0; miss_req_opcode = '0; miss_req_rob_id = '0;
    fetch_mem_req_rdy = 1'b1;
    fetch_mem_ack_vld = 1'b0; fetch_mem_ack_data = '0; fetch_mem_ack_entry_id = '0;
    refill_rdy = 1'b1;
    tick(); tick();
    check("rst_req_vld", 256'(fetch_mem_req_vld), 256'(0));
    check("rst_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(0));
    check("rst_refill_vld", 256'(refill_vld), 256'(0));
    check("rst_cnt", 256'(outstanding_cnt), 256'(0));
    check("rst_err", 256'(err_unexp_ack), 256'(0));
    rst = 1'b0;
    #1;
    check("post_rst_miss_rdy", 256'(miss_req_rdy), 256'(1));
    check("post_rst_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(1));

    // single miss, ack two cycles after the request handshake
    miss_req_vld = 1'b1; miss_req_addr = 32'h1000; miss_req_opcode = 2'd1; miss_req_rob_id = 4'd5;
    check("t1_cnt0", 256'(outstanding_cnt), 256'(0));
    tick();
    miss_req_vld = 1'b0;
    check("t1_req_vld", 256'(fetch_mem_req_vld), 256'(1));
    check("t1_req_id", 256'(fetch_mem_req_entry_id), 256'(8'h45));
    check("t1_req_addr", 256'(fetch_mem_req_addr), 256'(32'h1000));
    check("t1_cnt1", 256'(outstanding_cnt), 256'(1));
    tick();
    check("t1_req_popped", 256'(fetch_mem_req_vld), 256'(0));
    check("t1_cnt2", 256'(outstanding_cnt), 256'(1));
    tick();
    check("t1_cnt3", 256'(outstanding_cnt), 256'(1));
    send_ack(1, 0, 5, 100);
    tick();
    fetch_mem_ack_vld = 1'b0;
    check("t1_cnt4", 256'(outstanding_cnt), 256'(1));
    check("t1_refill_not_yet", 256'(refill_vld), 256'(0));
    tick();
    check("t1_refill_vld", 256'(refill_vld), 256'(1));
    check("t1_refill_addr", 256'(refill_addr), 256'(32'h1000));
    check("t1_refill_data", refill_data, line_data(100));
    check("t1_refill_rob", 256'(refill_rob_id), 256'(5));
    check("t1_refill_op", 256'(refill_opcode), 256'(1));
    check("t1_cnt5", 256'(outstanding_cnt), 256'(0));
    tick();
    check("t1_refill_drop", 256'(refill_vld), 256'(0));

    // four back-to-back misses issue in allocation order
    for (int i = 0; i < 4; i++) begin
      miss_req_vld = 1'b1;
      miss_req_addr = 32'h2000 + 32'(i) * 32'h40;
      miss_req_opcode = 2'(i);
      miss_req_rob_id = 4'(i + 8);
      check($sformatf("t2_miss_rdy_%0d", i), 256'(miss_req_rdy), 256'(1));
      tick();
      check($sformatf("t2_req_id_%0d", i), 256'(fetch_mem_req_entry_id), 256'(eid(i, i, i + 8)));
      check($sformatf("t2_req_addr_%0d", i), 256'(fetch_mem_req_addr), 256'(32'h2000 + 32'(i) * 32'h40));
    end
    miss_req_vld = 1'b0;
    check("t2_full_rdy", 256'(miss_req_rdy), 256'(0));
    check("t2_full_cnt", 256'(outstanding_cnt), 256'(4));
    tick();
    check("t2_all_issued", 256'(fetch_mem_req_vld), 256'(0));

    // out-of-order acks refill in ack order
    for (int k = 0; k < 4; k++) begin
      send_ack(ack_order[k], ack_order[k], ack_order[k] + 8, 200 + ack_order[k]);
      tick();
      if (k > 0) begin
        check($sformatf("t3_vld_%0d", k - 1), 256'(refill_vld), 256'(1));
        check($sformatf("t3_rob_%0d", k - 1), 256'(refill_rob_id), 256'(ack_order[k - 1] + 8));
        check($sformatf("t3_data_%0d", k - 1), refill_data, line_data(200 + ack_order[k - 1]));
      end
    end
    fetch_mem_ack_vld = 1'b0;
    tick();
    check("t3_vld_3", 256'(refill_vld), 256'(1));
    check("t3_rob_3", 256'(refill_rob_id), 256'(9));
    check("t3_addr_3", 256'(refill_addr), 256'(32'h2040));
    check("t3_data_3", refill_data, line_data(201));
    tick();
    check("t3_drained", 256'(refill_vld), 256'(0));
    check("t3_cnt", 256'(outstanding_cnt), 256'(0));

    // request backpressure with a second miss queued behind
    fetch_mem_req_rdy = 1'b0;
    miss_req_vld = 1'b1; miss_req_addr = 32'h3000; miss_req_opcode = 2'd2; miss_req_rob_id = 4'd3;
    tick();
    check("t4_a_id", 256'(fetch_mem_req_entry_id), 256'(8'h83));
    check("t4_a_addr", 256'(fetch_mem_req_addr), 256'(32'h3000));
    miss_req_addr = 32'h4000; miss_req_opcode = 2'd3; miss_req_rob_id = 4'd7;
    tick();
    miss_req_vld = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("t4_stable_vld_%0d", s), 256'(fetch_mem_req_vld), 256'(1));
      check($sformatf("t4_stable_id_%0d", s), 256'(fetch_mem_req_entry_id), 256'(8'h83));
      check($sformatf("t4_stable_addr_%0d", s), 256'(fetch_mem_req_addr), 256'(32'h3000));
      tick();
    end
    fetch_mem_req_rdy = 1'b1;
    tick();
    check("t4_b_id", 256'(fetch_mem_req_entry_id), 256'(8'hD7));
    check("t4_b_addr", 256'(fetch_mem_req_addr), 256'(32'h4000));
    tick();
    check("t4_b_popped", 256'(fetch_mem_req_vld), 256'(0));
    check("t4_cnt", 256'(outstanding_cnt), 256'(2));

    // ack naming a FREE entry
    send_ack(0, 2, 0, 300);
    tick();
    fetch_mem_ack_vld = 1'b0;
    check("t5_err_pulse", 256'(err_unexp_ack), 256'(1));
    check("t5_cnt", 256'(outstanding_cnt), 256'(2));
    check("t5_no_refill", 256'(refill_vld), 256'(0));
    tick();
    check("t5_err_clear", 256'(err_unexp_ack), 256'(0));
    check("t5_no_refill2", 256'(refill_vld), 256'(0));

    // refill stall fills every entry, then drains in index order
    refill_rdy = 1'b0;
    send_ack(2, 0, 3, 400);
    tick();
    send_ack(3, 1, 7, 401);
    tick();
    fetch_mem_ack_vld = 1'b0;
    check("t6_stage_vld", 256'(refill_vld), 256'(1));
    check("t6_stage_data", refill_data, line_data(400));
    check("t6_cnt1", 256'(outstanding_cnt), 256'(1));
    foreach (ack_order[j]) begin
      if (ack_order[j] != 1) begin
        miss_req_vld = 1'b1;
        miss_req_addr = 32'h5000 + 32'(ack_order[j]) * 32'h40;
        miss_req_opcode = 2'(ack_order[j]);
        miss_req_rob_id = 4'(ack_order[j]);
        tick();
      end
    end
    miss_req_vld = 1'b0;
    tick();
    check("t6_full_rdy", 256'(miss_req_rdy), 256'(0));
    check("t6_full_cnt", 256'(outstanding_cnt), 256'(4));
    // allocation order above was 2,0,3 -> idx 0,2,3 carry addr/op/rob of those loop values
    send_ack(0, 0, 0, 500);
    tick();
    send_ack(0, 2, 0, 502);
    tick();
    send_ack(0, 3, 0, 503);
    tick();
    fetch_mem_ack_vld = 1'b0;
    check("t6_stall_data", refill_data, line_data(400));
    check("t6_stall_rdy", 256'(miss_req_rdy), 256'(0));
    check("t6_stall_cnt", 256'(outstanding_cnt), 256'(4));
    refill_rdy = 1'b1;
    tick();
    check("t6_d0_data", refill_data, line_data(500));
    check("t6_d0_cnt", 256'(outstanding_cnt), 256'(3));
    tick();
    check("t6_d1_data", refill_data, line_data(401));
    check("t6_d1_addr", 256'(refill_addr), 256'(32'h4000));
    check("t6_d1_cnt", 256'(outstanding_cnt), 256'(2));
    rst = 1'b1;
    #1;
    check("t6_rst_refill_vld", 256'(refill_vld), 256'(0));
    check("t6_rst_refill_data", refill_data, 256'(0));
    check("t6_rst_refill_addr", 256'(refill_addr), 256'(0));
    check("t6_rst_req_vld", 256'(fetch_mem_req_vld), 256'(0));
    check("t6_rst_ack_rdy", 256'(fetch_mem_ack_rdy), 256'(0));
    check("t6_rst_cnt", 256'(outstanding_cnt), 256'(0));
    check("t6_rst_miss_rdy", 256'(miss_req_rdy), 256'(0));
    tick();
    rst = 1'b0;
    send_ack(0, 3, 0, 600);
    tick();
    fetch_mem_ack_vld = 1'b0;
    check("t6_stale_ack_err", 256'(err_unexp_ack), 256'(1));
    check("t6_stale_ack_cnt", 256'(outstanding_cnt), 256'(0));
    check("t6_stale_ack_refill", 256'(refill_vld), 256'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
